// File: rtl/tmds_rx_decoder.sv
// TMDS channel decoder with word-alignment FSM: finds control-token runs,
// requests bitslips until lock, and decodes control/data tokens once aligned.
module tmds_rx_decoder #(
  parameter int unsigned CTRL_MIN  = 64,
  parameter int unsigned SEARCH_TO = 4096,
  parameter int unsigned SLIP_WAIT = 3
) (
  input  logic       PCLKX1_i,
  input  logic       RSTn_i,
  input  logic [9:0] TMDS_D_i,
  output logic       BITSLIP_o,
  output logic       ALIGNED_o,
  output logic       LOCK_LOST_o,
  output logic       DE_o,
  output logic       C0_o,
  output logic       C1_o,
  output logic [7:0] D_o
);

  localparam int unsigned RUN_W  = $clog2(CTRL_MIN) + 1;
  localparam int unsigned TMR_W  = $clog2(SEARCH_TO) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_MIN - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_MIN);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_TO - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t            state_q, state_nxt;
  logic [RUN_W-1:0]  run_q, run_nxt;
  logic [TMR_W-1:0]  tmr_q, tmr_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;

  logic       is_ctrl;
  logic [1:0] ctrl_bits;
  logic [7:0] d_inv;
  logic [7:0] d_dec;

  logic       bitslip_nxt, aligned_nxt, lock_lost_nxt;
  logic       de_nxt, c0_nxt, c1_nxt;
  logic [7:0] d_nxt;

  // Control-token recognition; ctrl_bits is {C1,C0}
  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_bits = 2'b00;
    case (TMDS_D_i)
      10'b1101010100: ctrl_bits = 2'b00;
      10'b0010101011: ctrl_bits = 2'b01;
      10'b0101010100: ctrl_bits = 2'b10;
      10'b1010101011: ctrl_bits = 2'b11;
      default:        is_ctrl   = 1'b0;
    endcase
  end

  // Data-token decode: undo optional inversion, then the XOR/XNOR chain
  always_comb begin
    d_dec    = '0;
    d_inv    = TMDS_D_i[9] ? ~TMDS_D_i[7:0] : TMDS_D_i[7:0];
    d_dec[0] = d_inv[0];
    for (int i = 1; i < 8; i++) begin
      d_dec[i] = TMDS_D_i[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
    end
  end

  // Alignment FSM next-state, counters and output-register inputs
  always_comb begin
    state_nxt = state_q;
    run_nxt   = run_q;
    tmr_nxt   = tmr_q;
    wait_nxt  = wait_q;

    case (state_q)
      ST_SEARCH: begin
        tmr_nxt = tmr_q + TMR_W'(1);
        if (!is_ctrl)            run_nxt = '0;
        else if (run_q != RUN_MAX) run_nxt = run_q + RUN_W'(1);
        // Lock takes priority over a coincident timeout
        if (is_ctrl && (run_q == RUN_LAST)) begin
          state_nxt = ST_LOCKED;
          run_nxt   = '0;
          tmr_nxt   = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_nxt = ST_SLIP;
          run_nxt   = '0;
          tmr_nxt   = '0;
        end
      end
      ST_SLIP: begin
        state_nxt = ST_WAIT;
        wait_nxt  = '0;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_nxt = ST_SEARCH;
          wait_nxt  = '0;
          run_nxt   = '0;
          tmr_nxt   = '0;
        end else begin
          wait_nxt = wait_q + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (is_ctrl) begin
          tmr_nxt = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_nxt = ST_SEARCH;
          tmr_nxt   = '0;
          run_nxt   = '0;
        end else begin
          tmr_nxt = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        run_nxt   = '0;
        tmr_nxt   = '0;
        wait_nxt  = '0;
      end
    endcase

    bitslip_nxt   = (state_nxt == ST_SLIP) && (state_q == ST_SEARCH);
    lock_lost_nxt = (state_q == ST_LOCKED) && (state_nxt == ST_SEARCH);
    aligned_nxt   = (state_nxt == ST_LOCKED);

    // Decoded outputs follow the alignment flag that appears on the same edge
    de_nxt = 1'b0;
    c0_nxt = 1'b0;
    c1_nxt = 1'b0;
    d_nxt  = '0;
    if (aligned_nxt) begin
      if (is_ctrl) begin
        c0_nxt = ctrl_bits[0];
        c1_nxt = ctrl_bits[1];
      end else begin
        de_nxt = 1'b1;
        c0_nxt = C0_o;
        c1_nxt = C1_o;
        d_nxt  = d_dec;
      end
    end
  end

  always_ff @(posedge PCLKX1_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q     <= ST_SEARCH;
      run_q       <= '0;
      tmr_q       <= '0;
      wait_q      <= '0;
      BITSLIP_o   <= 1'b0;
      ALIGNED_o   <= 1'b0;
      LOCK_LOST_o <= 1'b0;
      DE_o        <= 1'b0;
      C0_o        <= 1'b0;
      C1_o        <= 1'b0;
      D_o         <= '0;
    end else begin
      state_q     <= state_nxt;
      run_q       <= run_nxt;
      tmr_q       <= tmr_nxt;
      wait_q      <= wait_nxt;
      BITSLIP_o   <= bitslip_nxt;
      ALIGNED_o   <= aligned_nxt;
      LOCK_LOST_o <= lock_lost_nxt;
      DE_o        <= de_nxt;
      C0_o        <= c0_nxt;
      C1_o        <= c1_nxt;
      D_o         <= d_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: lock, decode, loss, slip timing, tie and reset.
module tb_tmds_rx_decoder;

  localparam int unsigned CTRL_MIN  = 8;
  localparam int unsigned SEARCH_TO = 64;
  localparam int unsigned SLIP_WAIT = 3;

  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] CTRL01 = 10'b0010101011;
  localparam logic [9:0] CTRL10 = 10'b0101010100;
  localparam logic [9:0] CTRL11 = 10'b1010101011;
  localparam logic [9:0] DATA0  = 10'b0100000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tmds_d;
  logic       bitslip, aligned, lock_lost, de, c0, c1;
  logic [7:0] d;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int slip_cnt = 0;
  int ll_cnt   = 0;
  int both_cnt = 0;
  int lost_cyc = 0;
  int prev_slip = 0;
  int off      = 0;

  // word, expected {de,c1,c0,d}
  logic [9:0]  dec_w [9] = '{10'b1011111111, CTRL01, 10'b1000000000, CTRL11,
                             10'b0111110000, CTRL10, 10'b1011110000, 10'b0111111111,
                             CTRL00};
  logic [10:0] dec_e [9] = '{{3'b100, 8'hFE}, {3'b001, 8'h00}, {3'b101, 8'hFF},
                             {3'b011, 8'h00}, {3'b111, 8'h10}, {3'b010, 8'h00},
                             {3'b110, 8'hEF}, {3'b110, 8'h01}, {3'b000, 8'h00}};

  tmds_rx_decoder #(
    .CTRL_MIN (CTRL_MIN),
    .SEARCH_TO(SEARCH_TO),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .PCLKX1_i   (clk),
    .RSTn_i     (rst_n),
    .TMDS_D_i   (tmds_d),
    .BITSLIP_o  (bitslip),
    .ALIGNED_o  (aligned),
    .LOCK_LOST_o(lock_lost),
    .DE_o       (de),
    .C0_o       (c0),
    .C1_o       (c1),
    .D_o        (d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [13:0] outs();
    return {bitslip, aligned, lock_lost, de, c1, c0, d};
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int n);
    logic [19:0] x;
    x = {w, w} >> n;
    return x[9:0];
  endfunction

  // One clock: drive word, sample 1ns after the edge, tally pulses
  task automatic tick(input logic [9:0] w);
    tmds_d = w;
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip) slip_cnt++;
    if (lock_lost) ll_cnt++;
    if (bitslip && lock_lost) both_cnt++;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    tmds_d = DATA0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    cyc      = 0;
    slip_cnt = 0;
    ll_cnt   = 0;
    both_cnt = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    tmds_d = DATA0;
    #23;
    check("reset_outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Lock on 8 control tokens, then one data word
    repeat (7) tick(CTRL00);
    check("pre_lock_aligned", 32'(aligned), 32'd0);
    tick(CTRL00);
    check("lock_aligned", 32'(aligned), 32'd1);
    check("lock_ctrl_out", 32'({de, c1, c0, d}), 32'd0);
    tick(DATA0);
    check("lock_data", 32'({de, d}), 32'({1'b1, 8'h00}));
    check("lock_no_slip", 32'(slip_cnt), 32'd0);

    // Decode table
    for (int i = 0; i < 9; i++) begin
      tick(dec_w[i]);
      check($sformatf("dec%0d", i), 32'({de, c1, c0, d}), 32'(dec_e[i]));
    end

    // Loss of lock after 64 consecutive data words
    repeat (63) tick(DATA0);
    check("loss_pre", 32'({aligned, lock_lost}), 32'b10);
    tick(DATA0);
    check("loss_pulse", 32'({aligned, lock_lost, de}), 32'b010);
    lost_cyc = cyc;
    tick(DATA0);
    check("loss_one_cycle", 32'(lock_lost), 32'd0);
    repeat (62) tick(DATA0);
    check("no_slip_after_loss", 32'(slip_cnt), 32'd0);
    tick(DATA0);
    check("slip_after_loss", 32'(bitslip), 32'd1);
    check("slip_after_loss_cyc", 32'(cyc - lost_cyc), 32'd64);
    check("lock_lost_once", 32'(ll_cnt), 32'd1);
    check("no_overlap", 32'(both_cnt), 32'd0);

    // Reset asserted during WAIT
    tick(DATA0);
    check("wait_bitslip_low", 32'(bitslip), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_in_wait", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    cyc      = 0;
    slip_cnt = 0;
    repeat (63) tick(DATA0);
    check("post_reset_no_slip", 32'(slip_cnt), 32'd0);
    tick(DATA0);
    check("post_reset_slip64", 32'(bitslip), 32'd1);

    // Tie: 8th control token on timer = 63
    apply_reset();
    repeat (56) tick(DATA0);
    repeat (7) tick(CTRL00);
    check("tie_pre", 32'({aligned, slip_cnt[0]}), 32'b00);
    tick(CTRL00);
    check("tie_lock", 32'({aligned, bitslip}), 32'b10);
    repeat (5) tick(DATA0);
    check("tie_hold", 32'({aligned, 7'(slip_cnt)}), 32'({1'b1, 7'd0}));

    // Near miss: only 7 controls by timer = 63 -> slip
    apply_reset();
    repeat (57) tick(DATA0);
    repeat (7) tick(CTRL00);
    check("near_miss_slip", 32'({aligned, bitslip}), 32'b01);

    // Misaligned stream, rotated by 3 bits
    apply_reset();
    off       = 3;
    prev_slip = 0;
    for (int k = 0; k < 1000; k++) begin
      tick(rot(CTRL00, off));
      if (bitslip) begin
        if (slip_cnt == 1) check("slip_first", 32'(cyc), 32'd64);
        else               check($sformatf("slip_period%0d", slip_cnt), 32'(cyc - prev_slip), 32'd68);
        prev_slip = cyc;
        off       = (off + 1) % 10;
      end
      if (aligned) break;
    end
    check("misalign_slips", 32'(slip_cnt), 32'd7);
    check("misalign_locked", 32'(aligned), 32'd1);
    check("misalign_lock_delay", 32'(cyc - prev_slip), 32'd12);

    // Asynchronous reset while locked
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_locked", 32'(outs()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
